// File: rtl/prio_enc_pkg.sv
// Shared types and helpers for the sequential priority serializer.
package prio_enc_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  // Widest request vector the popcount helper handles; callers zero-extend.
  localparam int POP_MAX_W = 64;

  function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < POP_MAX_W; i++) begin
      c = c + {31'b0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/rr_prio_enc.sv
// Combinational priority encoder with a rotating start pointer.
// Finds the first set bit at or above start_i, wrapping modulo N.
module rr_prio_enc #(
  parameter  int N     = 8,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     mask_i,
  input  logic [IDX_W-1:0] start_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  logic [N-1:0]     rot;
  logic [IDX_W-1:0] off;
  logic [IDX_W:0]   sum;

  // Doubled vector shifted by the start pointer puts the wrapped search in bit order.
  assign rot = N'({mask_i, mask_i} >> start_i);

  always_comb begin
    off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off = IDX_W'(i);
      end
    end
  end

  always_comb begin
    sum = {1'b0, start_i} + {1'b0, off};
    if (sum >= (IDX_W + 1)'(N)) begin
      sum = sum - (IDX_W + 1)'(N);
    end
  end

  assign idx_o   = sum[IDX_W-1:0];
  assign valid_o = |mask_i;

endmodule

// File: rtl/prio_enc_seq.sv
// Sequential priority serializer: captures a request vector and emits each set index
// one per handshake. Define PRIO_ENC_SEQ_RR_EN for a persistent round-robin start pointer.
module prio_enc_seq
  import prio_enc_pkg::*;
#(
  parameter  int N     = 8,
  localparam int IDX_W = $clog2(N),
  localparam int CNT_W = $clog2(N + 1)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             flush_i,
  input  logic [N-1:0]     lines_i,
  input  logic             load_valid_i,
  output logic             load_ready_o,
  output logic [IDX_W-1:0] enc_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             last_o,
  output logic [CNT_W-1:0] cnt_o
);

  state_t           state_q, state_next;
  logic [N-1:0]     mask_q, mask_next;
  logic [IDX_W-1:0] start_ptr;
  logic [IDX_W-1:0] enc_idx;
  logic             enc_found;
  logic [CNT_W-1:0] pend_cnt;
  logic             in_drain;
  logic             hs;
  logic             load_acc;

  assign in_drain = (state_q == DRAIN);
  assign pend_cnt = CNT_W'(popcount(POP_MAX_W'(mask_q)));

  rr_prio_enc #(.N(N)) u_enc (
    .mask_i  (mask_q),
    .start_i (start_ptr),
    .idx_o   (enc_idx),
    .valid_o (enc_found)
  );

  assign valid_o      = in_drain;
  assign enc_o        = (in_drain && enc_found) ? enc_idx : '0;
  assign last_o       = in_drain && (pend_cnt == CNT_W'(1));
  assign cnt_o        = in_drain ? pend_cnt : '0;
  assign hs           = valid_o && ready_i;
  // Accepting on the final handshake gives zero-bubble back-to-back vectors.
  assign load_ready_o = !in_drain || (hs && last_o);
  assign load_acc     = load_valid_i && load_ready_o;

  always_comb begin
    state_next = state_q;
    mask_next  = mask_q;
    if (flush_i) begin
      state_next = IDLE;
      mask_next  = '0;
    end else begin
      if (hs) begin
        mask_next = mask_q & ~(N'(1) << enc_idx);
        if (last_o) begin
          state_next = IDLE;
        end
      end
      if (load_acc) begin
        if (|lines_i) begin
          mask_next  = lines_i;
          state_next = DRAIN;
        end else begin
          state_next = IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      mask_q  <= '0;
    end else begin
      state_q <= state_next;
      mask_q  <= mask_next;
    end
  end

`ifdef PRIO_ENC_SEQ_RR_EN
  logic [IDX_W-1:0] ptr_q, ptr_next;

  // Pointer survives loads and flushes; only a discarded (flushed) handshake leaves it alone.
  always_comb begin
    ptr_next = ptr_q;
    if (hs && !flush_i) begin
      ptr_next = (enc_idx == IDX_W'(N - 1)) ? '0 : enc_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_next;
    end
  end

  assign start_ptr = ptr_q;
`else
  assign start_ptr = '0;
`endif

endmodule

// File: tb/tb_prio_enc_seq.sv
// Directed self-checking bench for prio_enc_seq; inputs change and outputs are
// sampled 1 time unit after the falling edge.
module tb_prio_enc_seq;

  localparam int N = 8;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic [7:0] lines;
  logic       load_valid;
  logic       load_ready;
  logic [2:0] enc;
  logic       valid;
  logic       ready;
  logic       last;
  logic [3:0] cnt;

  int tests;
  int fails;

  prio_enc_seq #(.N(N)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .flush_i      (flush),
    .lines_i      (lines),
    .load_valid_i (load_valid),
    .load_ready_o (load_ready),
    .enc_o        (enc),
    .valid_o      (valid),
    .ready_i      (ready),
    .last_o       (last),
    .cnt_o        (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish (got running, want finished)");
    $fatal(1, "timeout");
  end

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; lines = '0; load_valid = 1'b0; ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %0b want 0", valid); end
    tests++; if (last !== 1'b0) begin fails++; $display("FAIL reset_last got %0b want 0", last); end
    tests++; if (enc !== 3'd0) begin fails++; $display("FAIL reset_enc got %0d want 0", enc); end
    tests++; if (cnt !== 4'd0) begin fails++; $display("FAIL reset_cnt got %0d want 0", cnt); end
    tests++; if (load_ready !== 1'b1) begin fails++; $display("FAIL reset_load_ready got %0b want 1", load_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL post_reset_valid got %0b want 0", valid); end
    $display("[TB] reset done");
  endtask

  task automatic test_fixed();
    int exp_enc[4];
    int exp_cnt[4];
    exp_enc = '{1, 2, 5, 7};
    exp_cnt = '{4, 3, 2, 1};
    @(negedge clk);
    lines = 8'b1010_0110; load_valid = 1'b1; ready = 1'b1;
    #1;
    tests++; if (load_ready !== 1'b1) begin fails++; $display("FAIL fixed_load_ready got %0b want 1", load_ready); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      load_valid = 1'b0;
      #1;
      tests++; if (valid !== 1'b1) begin fails++; $display("FAIL fixed_valid[%0d] got %0b want 1", i, valid); end
      tests++; if (enc !== 3'(exp_enc[i])) begin fails++; $display("FAIL fixed_enc[%0d] got %0d want %0d", i, enc, exp_enc[i]); end
      tests++; if (cnt !== 4'(exp_cnt[i])) begin fails++; $display("FAIL fixed_cnt[%0d] got %0d want %0d", i, cnt, exp_cnt[i]); end
      tests++; if (last !== (i == 3)) begin fails++; $display("FAIL fixed_last[%0d] got %0b want %0b", i, last, (i == 3)); end
      $display("[TB] fixed emit enc=%0d cnt=%0d last=%0b", enc, cnt, last);
    end
    @(negedge clk);
    #1;
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL fixed_idle_valid got %0b want 0", valid); end
    tests++; if (cnt !== 4'd0) begin fails++; $display("FAIL fixed_idle_cnt got %0d want 0", cnt); end
    tests++; if (load_ready !== 1'b1) begin fails++; $display("FAIL fixed_idle_load_ready got %0b want 1", load_ready); end
  endtask

  task automatic test_backpressure();
    int exp_enc[4];
    exp_enc = '{1, 2, 5, 7};
    @(negedge clk);
    lines = 8'b1010_0110; load_valid = 1'b1; ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      load_valid = 1'b0;
      #1;
      tests++; if (enc !== 3'd1 || cnt !== 4'd4 || valid !== 1'b1 || last !== 1'b0) begin
        fails++; $display("FAIL bp_hold[%0d] got enc=%0d cnt=%0d valid=%0b last=%0b want enc=1 cnt=4 valid=1 last=0", i, enc, cnt, valid, last);
      end
      tests++; if (load_ready !== 1'b0) begin fails++; $display("FAIL bp_load_ready[%0d] got %0b want 0", i, load_ready); end
      $display("[TB] backpressure hold enc=%0d cnt=%0d", enc, cnt);
    end
    ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      #1;
      tests++; if (enc !== 3'(exp_enc[i]) || cnt !== 4'(4 - i)) begin
        fails++; $display("FAIL bp_resume[%0d] got enc=%0d cnt=%0d want enc=%0d cnt=%0d", i, enc, cnt, exp_enc[i], 4 - i);
      end
      $display("[TB] backpressure resume enc=%0d cnt=%0d", enc, cnt);
    end
    @(negedge clk);
    #1;
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL bp_idle_valid got %0b want 0", valid); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    lines = 8'b1010_0110; load_valid = 1'b1; ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      load_valid = 1'b0;
    end
    @(negedge clk);
    lines = 8'b0000_0001; load_valid = 1'b1;
    #1;
    tests++; if (enc !== 3'd7 || last !== 1'b1) begin fails++; $display("FAIL b2b_last got enc=%0d last=%0b want enc=7 last=1", enc, last); end
    tests++; if (load_ready !== 1'b1) begin fails++; $display("FAIL b2b_load_ready got %0b want 1", load_ready); end
    $display("[TB] b2b final enc=%0d load_ready=%0b", enc, load_ready);
    @(negedge clk);
    load_valid = 1'b0;
    #1;
    tests++; if (valid !== 1'b1 || enc !== 3'd0 || cnt !== 4'd1 || last !== 1'b1) begin
      fails++; $display("FAIL b2b_next got valid=%0b enc=%0d cnt=%0d last=%0b want valid=1 enc=0 cnt=1 last=1", valid, enc, cnt, last);
    end
    $display("[TB] b2b new enc=%0d", enc);
    @(negedge clk);
    #1;
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL b2b_idle got valid=%0b want 0", valid); end
  endtask

  task automatic test_zero_vector();
    @(negedge clk);
    lines = 8'h00; load_valid = 1'b1; ready = 1'b1;
    #1;
    tests++; if (load_ready !== 1'b1) begin fails++; $display("FAIL zero_load_ready got %0b want 1", load_ready); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      load_valid = 1'b0;
      #1;
      tests++; if (valid !== 1'b0 || cnt !== 4'd0 || load_ready !== 1'b1) begin
        fails++; $display("FAIL zero_idle[%0d] got valid=%0b cnt=%0d load_ready=%0b want 0 0 1", i, valid, cnt, load_ready);
      end
      $display("[TB] zero vector cycle %0d valid=%0b", i, valid);
    end
  endtask

  task automatic test_flush();
    @(negedge clk);
    lines = 8'hFF; load_valid = 1'b1; ready = 1'b0;
    @(negedge clk);
    load_valid = 1'b0;
    #1;
    tests++; if (valid !== 1'b1 || cnt !== 4'd8) begin fails++; $display("FAIL flush_loaded got valid=%0b cnt=%0d want 1 8", valid, cnt); end
    ready = 1'b1;
    @(negedge clk);
    flush = 1'b1; lines = 8'h0F; load_valid = 1'b1;
    #1;
    tests++; if (cnt !== 4'd7) begin fails++; $display("FAIL flush_after_emit got cnt=%0d want 7", cnt); end
    tests++; if (load_ready !== 1'b0) begin fails++; $display("FAIL flush_load_ready got %0b want 0", load_ready); end
    @(negedge clk);
    flush = 1'b0; load_valid = 1'b0;
    #1;
    tests++; if (valid !== 1'b0 || cnt !== 4'd0) begin fails++; $display("FAIL flush_cleared got valid=%0b cnt=%0d want 0 0", valid, cnt); end
    @(negedge clk);
    #1;
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL flush_load_discarded got valid=%0b want 0", valid); end
    $display("[TB] flush done valid=%0b cnt=%0d", valid, cnt);
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    lines = 8'b1010_0110; load_valid = 1'b1; ready = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    #1;
    tests++; if (valid !== 1'b1 || cnt !== 4'd4) begin fails++; $display("FAIL areset_pre got valid=%0b cnt=%0d want 1 4", valid, cnt); end
    rst_n = 1'b0;
    #1;
    tests++; if (valid !== 1'b0 || cnt !== 4'd0 || load_ready !== 1'b1) begin
      fails++; $display("FAIL areset_now got valid=%0b cnt=%0d load_ready=%0b want 0 0 1", valid, cnt, load_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL areset_after got valid=%0b want 0", valid); end
    $display("[TB] async reset valid=%0b", valid);
  endtask

`ifdef PRIO_ENC_SEQ_RR_EN
  task automatic test_rr();
    int exp_a[3];
    exp_a = '{6, 0, 3};
    @(negedge clk);
    lines = 8'b0010_0000; load_valid = 1'b1; ready = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    #1;
    tests++; if (enc !== 3'd5) begin fails++; $display("FAIL rr_first got enc=%0d want 5", enc); end
    @(negedge clk);
    lines = 8'b0100_1001; load_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      load_valid = 1'b0;
      #1;
      tests++; if (enc !== 3'(exp_a[i])) begin fails++; $display("FAIL rr_order[%0d] got enc=%0d want %0d", i, enc, exp_a[i]); end
      $display("[TB] rr emit enc=%0d", enc);
    end
    @(negedge clk);
    lines = 8'h80; load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    #1;
    tests++; if (enc !== 3'd7) begin fails++; $display("FAIL rr_seven got enc=%0d want 7", enc); end
    @(negedge clk);
    lines = 8'h81; load_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      load_valid = 1'b0;
      #1;
      tests++; if (enc !== ((i == 0) ? 3'd0 : 3'd7)) begin fails++; $display("FAIL rr_wrap[%0d] got enc=%0d want %0d", i, enc, (i == 0) ? 0 : 7); end
      $display("[TB] rr wrap enc=%0d", enc);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_fixed();
    test_backpressure();
    test_back_to_back();
    test_zero_vector();
    test_flush();
    test_async_reset();
`ifdef PRIO_ENC_SEQ_RR_EN
    test_rr();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/prio_enc_seq.md
# prio_enc_seq

Sequential priority serializer. Captures an N-bit request vector in one cycle, then emits the index of every set line, one per handshake, in priority order. It sits between producers that raise multiple requests at once (e.g. issue-queue ready masks, exception/commit masks) and consumers that can service one index per cycle. It is the stateful, flow-controlled successor of the fixed-priority combinational encoder. It adds buffering, valid/ready handshaking, back-to-back loads, flush, and an optional round-robin start pointer.

## Interface
- `N`, 8: number of request lines (N ≥ 2).
- `IDX_W`, `$clog2(N)`: index width (derived, not overridable).
- `CNT_W`, `$clog2(N+1)`: pending-count width (derived).

- `clk_i`, in, 1: clock. Single clock domain.
- `rst_n_i`, in, 1: reset. Asynchronous, active-low.
- `flush_i`, in, 1: synchronous flush. Drops all pending lines.
- `lines_i`, in, N: request vector. Bit 0 is highest priority in fixed mode.
- `load_valid_i`, in, 1: `lines_i` is valid.
- `load_ready_o`, out, 1: the block can accept a new vector.
- `enc_o`, out, IDX_W: index of the current highest-priority pending line.
- `valid_o`, out, 1: `enc_o` is valid.
- `ready_i`, in, 1: the consumer accepts `enc_o`.
- `last_o`, out, 1: `enc_o` is the last pending line of the vector.
- `cnt_o`, out, CNT_W: number of pending lines, including the one on `enc_o`.

## Operation
- State machine with states IDLE and DRAIN. Reset state is IDLE.
- Registers: `mask_q` (N bits) holds the pending lines.
- IDLE:
  - `load_ready_o=1`.
  - A load is accepted when `load_valid_i && load_ready_o`.
  - If `lines_i` is nonzero: `mask_q<=lines_i` and go to DRAIN.
  - If `lines_i` is all zero: the load is accepted, nothing is emitted, and the block stays in IDLE.
- DRAIN:
  - `valid_o=1`.
  - `enc_o` = first set bit of `mask_q` in priority order.
  - `last_o` = (popcount(`mask_q`)==1).
  - On `valid_o && ready_i`, clear the bit at `enc_o` in `mask_q`.
  - If `last_o` is also set, go to IDLE, unless a load is accepted in the same cycle (see below).
  - While `ready_i=0`, `enc_o`, `last_o` and `cnt_o` hold stable.
- Back-to-back loads:
  - `load_ready_o = IDLE || (valid_o && ready_i && last_o)`. This is a combinational path from `ready_i`.
  - A load accepted in the same cycle as the last handshake goes directly to DRAIN with the new mask.
  - If that new vector is all zero, the next state is IDLE.
- `cnt_o` = popcount(`mask_q`). It is 0 in IDLE.
- `flush_i` has priority over every other event:
  - Next state is IDLE and `mask_q<=0`.
  - A load or handshake in the same cycle is discarded.
  - `load_ready_o` is still driven normally during the flush cycle, but the handshake has no effect.
- Outputs are don't-care-free: in IDLE, `enc_o=0`, `last_o=0`, `valid_o=0`.

## Timing
- Reset values: `valid_o=0`, `last_o=0`, `enc_o=0`, `cnt_o=0`, `load_ready_o=1`. The round-robin pointer is reset to 0.
- Latency: a load accepted at edge t produces `valid_o=1` with the first index in the cycle after t.
- Throughput: one index per cycle while `ready_i=1`.
- A vector with k set bits drains in k cycles.
- A new vector's first index follows the previous vector's last index with zero bubbles.
- Asserting reset mid-drain immediately clears state (asynchronous). No outputs are pending after release.

## Configuration
- Macro: `PRIO_ENC_SEQ_RR_EN`.
- Defined:
  - A pointer register `ptr_q` (IDX_W bits) selects the highest-priority index.
  - The search runs ascending from `ptr_q` and wraps modulo N.
  - On each handshake, `ptr_q <= (enc_o+1) mod N`. When `enc_o=N-1`, it wraps to 0.
  - `ptr_q` persists across loads and flushes. It is reset to 0 only by `rst_n_i`.
- Undefined:
  - Fixed priority, with index 0 highest.
  - No pointer register.
  - Order is strictly ascending.

## Structure
- Shared package `prio_enc_pkg`: the state enum type (IDLE, DRAIN) and the popcount function.
- Sub-module `rr_prio_enc`: combinational encoder taking (mask, start pointer) and returning (index, valid).
  - In fixed mode the start pointer is tied to 0.
  - Implement it with a doubled-vector or masked two-pass search.

## Test plan
- Fixed priority, N=8:
  - Stimulus: load `8'b1010_0110` with `ready_i=1`.
  - Required: `enc_o`=1,2,5,7 on consecutive cycles; `last_o` only with 7; `cnt_o`=4,3,2,1; then IDLE.
- Backpressure:
  - Stimulus: same vector, `ready_i=0` for 3 cycles, then 1.
  - Required: `enc_o=1` and `cnt_o=4` are held for 3 cycles, then draining resumes.
- Back-to-back:
  - Stimulus: during the `last_o` handshake (index 7), present `8'b0000_0001`.
  - Required: `load_ready_o=1` in that cycle and `enc_o=0` in the next cycle, with no bubble.
- Zero vector:
  - Stimulus: load `8'h00`.
  - Required: accepted; `valid_o` stays 0; state stays IDLE.
- Flush:
  - Stimulus: after the first emit of `8'hFF`, assert `flush_i` together with `ready_i` and `load_valid_i`.
  - Required: next cycle `valid_o=0` and `cnt_o=0`; the load is discarded.
- `PRIO_ENC_SEQ_RR_EN`:
  - Stimulus: emit index 5 from `8'b0010_0000`, then load `8'b0100_1001`.
  - Required: emission order 6, 0, 3.
  - Stimulus: emit index 7, then load `8'h81`.
  - Required: order 0, 7 (wrap).
